// File: rtl/quad_sum_scaler_pkg.sv
// Shared constants for the quad_sum_scaler position-bus block.
//   DATA_W  : position-bus word width (two's complement).
//   ACC_W   : internal accumulator width. It is wide enough that four
//             negated/non-negated 32-bit terms can never overflow.
//   scale_e : encoding of the SCALE control (power-of-two divide).
package quad_sum_scaler_pkg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned ACC_W  = 35;

  typedef enum logic [1:0] {
    SCALE_DIV1 = 2'd0,
    SCALE_DIV2 = 2'd1,
    SCALE_DIV4 = 2'd2,
    SCALE_DIV8 = 2'd3
  } scale_e;

endpackage

// File: rtl/sign_extend_negate.sv
// Stage-1 operand conditioning for quad_sum_scaler.
// Sign-extends a 32-bit two's complement operand to the accumulator width
// and optionally negates it, then registers the result.
// Ports:
//   clk_i     : system clock, rising edge
//   reset_n_i : synchronous active-low reset, clears the register
//   data_i    : 32-bit signed operand
//   invert_i  : 1 = register the negated operand
//   term_o    : 35-bit registered signed term
module sign_extend_negate
  import quad_sum_scaler_pkg::*;
(
  input  logic              clk_i,
  input  logic              reset_n_i,
  input  logic [DATA_W-1:0] data_i,
  input  logic              invert_i,
  output logic [ACC_W-1:0]  term_o
);

  logic [ACC_W-1:0] ext;

  // Extension happens before negation so that -(0x80000000) is +2^31.
  always_comb begin
    ext = {{(ACC_W-DATA_W){data_i[DATA_W-1]}}, data_i};
  end

  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      term_o <= '0;
    end else begin
      term_o <= invert_i ? -ext : ext;
    end
  end

endmodule

// File: rtl/quad_sum_scaler.sv
// Four-input signed adder with per-input optional negation and a
// selectable power-of-two divide on the result. Two-stage pipeline:
// stage 1 conditions the operands and captures SCALE, stage 2 sums,
// shifts (floor) and truncates to 32 bits. Latency 2, throughput 1.
// Ports:
//   clk_i       : system clock, rising edge
//   reset_n_i   : synchronous active-low reset, clears every stage
//   inpa_i..d_i : 32-bit two's complement operands
//   INP*_INVERT : 1 = use the negated operand
//   SCALE       : result right-shift amount (0..3 => /1,/2,/4,/8)
//   out_o       : scaled sum, wraps modulo 2^32
module quad_sum_scaler
  import quad_sum_scaler_pkg::*;
(
  input  logic              clk_i,
  input  logic              reset_n_i,
  input  logic [DATA_W-1:0] inpa_i,
  input  logic [DATA_W-1:0] inpb_i,
  input  logic [DATA_W-1:0] inpc_i,
  input  logic [DATA_W-1:0] inpd_i,
  input  logic              INPA_INVERT,
  input  logic              INPB_INVERT,
  input  logic              INPC_INVERT,
  input  logic              INPD_INVERT,
  input  logic [1:0]        SCALE,
  output logic [DATA_W-1:0] out_o
);

  logic [ACC_W-1:0]        term_a;
  logic [ACC_W-1:0]        term_b;
  logic [ACC_W-1:0]        term_c;
  logic [ACC_W-1:0]        term_d;
  scale_e                  scale_q;
  logic signed [ACC_W-1:0] sum;

  // Stage 1: operand conditioning
  sign_extend_negate u_sen_a (
    .clk_i     (clk_i),
    .reset_n_i (reset_n_i),
    .data_i    (inpa_i),
    .invert_i  (INPA_INVERT),
    .term_o    (term_a)
  );

  sign_extend_negate u_sen_b (
    .clk_i     (clk_i),
    .reset_n_i (reset_n_i),
    .data_i    (inpb_i),
    .invert_i  (INPB_INVERT),
    .term_o    (term_b)
  );

  sign_extend_negate u_sen_c (
    .clk_i     (clk_i),
    .reset_n_i (reset_n_i),
    .data_i    (inpc_i),
    .invert_i  (INPC_INVERT),
    .term_o    (term_c)
  );

  sign_extend_negate u_sen_d (
    .clk_i     (clk_i),
    .reset_n_i (reset_n_i),
    .data_i    (inpd_i),
    .invert_i  (INPD_INVERT),
    .term_o    (term_d)
  );

  // SCALE travels with its operands so a control change never mixes stages.
  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      scale_q <= SCALE_DIV1;
    end else begin
      scale_q <= scale_e'(SCALE);
    end
  end

  // Stage 2: sum, arithmetic shift (floor), truncate
  always_comb begin
    sum = $signed(term_a) + $signed(term_b) + $signed(term_c) + $signed(term_d);
  end

  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      out_o <= '0;
    end else begin
      out_o <= DATA_W'(sum >>> scale_q);
    end
  end

endmodule

// File: tb/tb_quad_sum_scaler.sv
module tb_quad_sum_scaler;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] a, b, c, d;
  logic [3:0]  inv;
  logic [1:0]  sc;
  logic [31:0] out;

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;

  // model state: expected output now, and result of the operands in flight
  logic [31:0] exp_out;
  logic [31:0] exp_s1;

  always #5 clk = ~clk;

  quad_sum_scaler dut (
    .clk_i       (clk),
    .reset_n_i   (rst_n),
    .inpa_i      (a),
    .inpb_i      (b),
    .inpc_i      (c),
    .inpd_i      (d),
    .INPA_INVERT (inv[0]),
    .INPB_INVERT (inv[1]),
    .INPC_INVERT (inv[2]),
    .INPD_INVERT (inv[3]),
    .SCALE       (sc),
    .out_o       (out)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] expv);
    n_cmp++;
    if (got !== expv) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, expv, $time);
    end
  endtask

  // Full result from plain integer arithmetic: signed sum, floor divide, wrap.
  function automatic logic [31:0] ref_result(input logic [31:0] va, input logic [31:0] vb,
                                             input logic [31:0] vc, input logic [31:0] vd,
                                             input logic [3:0] vinv, input logic [1:0] vsc);
    logic [31:0] ops [4];
    longint s;
    longint t;
    longint dv;
    longint q;
    ops[0] = va; ops[1] = vb; ops[2] = vc; ops[3] = vd;
    s = 0;
    for (int i = 0; i < 4; i++) begin
      t = longint'($signed(ops[i]));
      if (vinv[i]) t = -t;
      s += t;
    end
    dv = longint'(1) << vsc;
    if (s >= 0) q = s / dv;
    else        q = -((-s + dv - 1) / dv);
    return q[31:0];
  endfunction

  // One clock edge: advance the model with the inputs sampled, then check.
  task automatic tick();
    @(posedge clk);
    if (!rst_n) begin
      exp_out = '0;
      exp_s1  = '0;
    end else begin
      exp_out = exp_s1;
      exp_s1  = ref_result(a, b, c, d, inv, sc);
    end
    #1;
    check_eq("pipe", out, exp_out);
  endtask

  task automatic apply(input logic [31:0] va, input logic [31:0] vb, input logic [31:0] vc,
                       input logic [31:0] vd, input logic [3:0] vinv, input logic [1:0] vsc);
    a = va; b = vb; c = vc; d = vd; inv = vinv; sc = vsc;
  endtask

  function automatic logic [31:0] rand_operand();
    case ($urandom_range(0, 5))
      0:       return 32'h8000_0000;
      1:       return 32'h7FFF_FFFF;
      2:       return 32'hFFFF_FFFF;
      default: return $urandom();
    endcase
  endfunction

  initial begin
    rst_n = 1'b0;
    apply(32'd5, 32'd6, 32'd0, 32'd0, 4'b0000, 2'd0);

    // reset hold
    repeat (3) begin
      tick();
      check_eq("reset_hold", out, 32'd0);
    end
    rst_n = 1'b1;
    tick();
    check_eq("reset_release_1", out, 32'd0);
    tick();
    check_eq("reset_release_2", out, 32'd11);

    // plain sum and latency
    apply(32'd1, 32'd2, 32'd3, 32'd4, 4'b0000, 2'd0);
    tick(); tick();
    check_eq("sum10", out, 32'd10);
    a = 32'd100;
    tick();
    check_eq("step_lat1", out, 32'd10);
    tick();
    check_eq("step_lat2", out, 32'd109);

    // inversion
    apply(32'd10, 32'd3, 32'd0, 32'd0, 4'b0010, 2'd0);
    tick(); tick();
    check_eq("inv_b", out, 32'd7);
    inv = 4'b0011;
    tick(); tick();
    check_eq("inv_ab", out, 32'hFFFF_FFF3);

    // scaling
    apply(32'd100, 32'd0, 32'd0, 32'd0, 4'b0000, 2'd1);
    tick(); tick();
    check_eq("scale1", out, 32'd50);
    sc = 2'd2;
    tick(); tick();
    check_eq("scale2", out, 32'd25);
    sc = 2'd3;
    tick(); tick();
    check_eq("scale3", out, 32'd12);
    apply(32'hFFFF_FFF9, 32'd0, 32'd0, 32'd0, 4'b0000, 2'd1);
    tick(); tick();
    check_eq("floor_neg", out, 32'hFFFF_FFFC);

    // extremes
    apply(32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 4'b0000, 2'd2);
    tick(); tick();
    check_eq("max_pos", out, 32'h7FFF_FFFF);
    apply(32'h8000_0000, 32'h8000_0000, 32'h8000_0000, 32'h8000_0000, 4'b1111, 2'd3);
    tick(); tick();
    check_eq("neg_min_s3", out, 32'h4000_0000);
    sc = 2'd0;
    tick(); tick();
    check_eq("neg_min_wrap", out, 32'h0000_0000);
    inv = 4'b0000;
    sc  = 2'd3;
    tick(); tick();
    check_eq("min_s3", out, 32'hC000_0000);

    // back-to-back random streaming with a mid-stream reset
    for (int i = 0; i < 300; i++) begin
      apply(rand_operand(), rand_operand(), rand_operand(), rand_operand(),
            4'($urandom_range(0, 15)), 2'($urandom_range(0, 3)));
      rst_n = (i == 150 || i == 151) ? 1'b0 : 1'b1;
      tick();
    end
    rst_n = 1'b1;
    tick(); tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
